// File: rtl/rcpu_mem_pkg.sv
// Shared constants and state encoding for the rcpu memory arbiter.
// The FSM encoding is one-hot per grant so each gnt output is a flop bit.
package rcpu_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_GRANT0 = GRANT0,
    ST_GRANT1 = GRANT1
  } arb_state_e;

  function automatic arb_state_e grantState(input logic port);
    return (port == PORT_DMA) ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = rcpu_mem_pkg::ADDR_W,
  parameter int DATA_W = rcpu_mem_pkg::DATA_W
) ();

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWrite;
  logic              memWE;
  logic [DATA_W-1:0] memRead;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output memAddr, memWrite, memWE,
    input  memRead
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  memAddr, memWrite, memWE,
    output memRead
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way picker: with both ports eligible, round-robin mode
// favours the port that was not granted last, otherwise the CPU port wins.
module rr_pick2
  import rcpu_mem_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  input  logic       rrEn,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |eligible;
    winner = eligible[1];
    if (eligible == 2'b11) begin
      winner = rrEn ? ~last : PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous RAM; all RAM-side
// outputs are registered. Define MEM_ARB_ROUND_ROBIN_EN for fair alternation.
module mem_arbiter #(
  parameter int ADDR_W = rcpu_mem_pkg::ADDR_W,
  parameter int DATA_W = rcpu_mem_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  import rcpu_mem_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e        state_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWrite_q;
  logic              memWE_q;
  logic              lastGnt_q;
  logic              rdPend_q;
  logic              rdPort_q;
  logic              rvalid0_q;
  logic              rvalid1_q;

  logic [1:0]        eligible;
  logic              pickValid;
  logic              pickWinner;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              selWe;

  // A port in its own grant cycle is masked so a held request cannot win twice in a row.
  always_comb begin
    eligible = {bus.req1 & ~state_q[1], bus.req0 & ~state_q[0]};
    selAddr  = pickWinner ? bus.addr1  : bus.addr0;
    selWdata = pickWinner ? bus.wdata1 : bus.wdata0;
    selWe    = pickWinner ? bus.we1    : bus.we0;
  end

  rr_pick2 u_pick (
    .eligible (eligible),
    .last     (lastGnt_q),
    .rrEn     (RR_EN),
    .valid    (pickValid),
    .winner   (pickWinner)
  );

  // Reset drops any in-flight read so no rvalid appears after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      memAddr_q  <= '0;
      memWrite_q <= '0;
      memWE_q    <= 1'b0;
      lastGnt_q  <= PORT_DMA;
      rdPend_q   <= 1'b0;
      rdPort_q   <= PORT_CPU;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid0_q <= rdPend_q & (rdPort_q == PORT_CPU);
      rvalid1_q <= rdPend_q & (rdPort_q == PORT_DMA);
      if (pickValid) begin
        state_q    <= grantState(pickWinner);
        memAddr_q  <= selAddr;
        memWrite_q <= selWdata;
        memWE_q    <= selWe;
        lastGnt_q  <= pickWinner;
        rdPend_q   <= ~selWe;
        rdPort_q   <= pickWinner;
      end else begin
        state_q  <= ST_IDLE;
        memWE_q  <= 1'b0;
        rdPend_q <= 1'b0;
      end
    end
  end

  // Read data is a combinational pass-through of the RAM, gated per port by rvalid.
  always_comb begin
    bus.gnt0     = state_q[0];
    bus.gnt1     = state_q[1];
    bus.memAddr  = memAddr_q;
    bus.memWrite = memWrite_q;
    bus.memWE    = memWE_q;
    bus.rvalid0  = rvalid0_q;
    bus.rvalid1  = rvalid1_q;
    bus.rdata0   = rvalid0_q ? bus.memRead : '0;
    bus.rdata1   = rvalid1_q ? bus.memRead : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model with a shadow RAM.
module tb_mem_arbiter;

  import rcpu_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit MODEL_RR = 1'b1;
`else
  localparam bit MODEL_RR = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  // Environment RAM: synchronous read, write captured at the edge ending the access cycle.
  logic [15:0] ram    [0:65535];
  logic [15:0] shadow [0:65535];

  always @(posedge clk) begin
    if (bus.memWE) ram[bus.memAddr] <= bus.memWrite;
    bus.memRead <= ram[bus.memAddr];
  end

  // Reference model state: what each output should be during the current cycle.
  bit [1:0]    mGnt;
  logic [15:0] mAddr;
  logic [15:0] mWData;
  bit          mWE;
  int          mLast;
  bit          mPend;
  int          mPendPort;
  logic [15:0] mPendData;
  bit [1:0]    mRv;
  logic [15:0] mRd [2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void modelReset();
    mGnt      = 2'b00;
    mAddr     = 16'h0000;
    mWData    = 16'h0000;
    mWE       = 1'b0;
    mLast     = 1;
    mPend     = 1'b0;
    mPendPort = 0;
    mPendData = 16'h0000;
    mRv       = 2'b00;
    mRd[0]    = 16'h0000;
    mRd[1]    = 16'h0000;
  endfunction

  function automatic void modelStep();
    bit [1:0]    elig;
    int          w;
    logic [15:0] a;
    logic [15:0] d;
    bit          we;
    elig   = {bus.req1, bus.req0} & ~mGnt;
    mRv    = 2'b00;
    mRd[0] = 16'h0000;
    mRd[1] = 16'h0000;
    if (mPend) begin
      mRv[mPendPort] = 1'b1;
      mRd[mPendPort] = mPendData;
    end
    mPend = 1'b0;
    mGnt  = 2'b00;
    mWE   = 1'b0;
    if (elig != 2'b00) begin
      if (elig == 2'b11) w = MODEL_RR ? 1 - mLast : 0;
      else               w = elig[1] ? 1 : 0;
      a  = (w == 1) ? bus.addr1  : bus.addr0;
      d  = (w == 1) ? bus.wdata1 : bus.wdata0;
      we = (w == 1) ? bus.we1    : bus.we0;
      mGnt[w] = 1'b1;
      mAddr   = a;
      mWData  = d;
      mWE     = we;
      mLast   = w;
      if (we) shadow[a] = d;
      else begin
        mPend     = 1'b1;
        mPendPort = w;
        mPendData = shadow[a];
      end
    end
  endfunction

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) modelReset();
      else      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("gnt0",     32'(bus.gnt0),     32'(mGnt[0]));
        checkOutput("gnt1",     32'(bus.gnt1),     32'(mGnt[1]));
        checkOutput("memAddr",  32'(bus.memAddr),  32'(mAddr));
        checkOutput("memWrite", 32'(bus.memWrite), 32'(mWData));
        checkOutput("memWE",    32'(bus.memWE),    32'(mWE));
        checkOutput("rvalid0",  32'(bus.rvalid0),  32'(mRv[0]));
        checkOutput("rvalid1",  32'(bus.rvalid1),  32'(mRv[1]));
        checkOutput("rdata0",   32'(bus.rdata0),   32'(mRd[0]));
        checkOutput("rdata1",   32'(bus.rdata1),   32'(mRd[1]));
      end
    end
  end

  task automatic applyStimulus(input int p, input logic r, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic waitGrant(input int p);
    bit granted = 1'b0;
    for (int n = 0; n < 20 && !granted; n++) begin
      @(negedge clk);
      granted = (p == 0) ? bus.gnt0 : bus.gnt1;
    end
    checkOutput("grantWait", 32'(granted), 32'd1);
  endtask

  task automatic doAccess(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    applyStimulus(p, 1'b1, w, a, d);
    waitGrant(p);
    @(posedge clk); #1;
    applyStimulus(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    bit [1:0]    g;
    logic [31:0] rnd;
    logic [15:0] ra;
    logic [15:0] rd;
    rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 16'(i) ^ 16'h5A5A;
      shadow[i] = 16'(i) ^ 16'h5A5A;
    end
    ram[5]    = 16'h1234;
    shadow[5] = 16'h1234;

    idle(3);
    #3 rst = 1'b1;
    checkEn = 1'b1;
    idle(2);

    $display("[TB] single read");
    doAccess(0, 1'b0, 16'h0005, 16'h0000);
    idle(3);

    $display("[TB] write then read back");
    doAccess(1, 1'b1, 16'hCFF0, 16'hBEEF);
    doAccess(0, 1'b0, 16'hCFF0, 16'h0000);
    idle(3);

    $display("[TB] reset during read");
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    waitGrant(0);
    #2 rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(2);
    #3 rst = 1'b1;
    idle(4);

    $display("[TB] contention");
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(6); #1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(3);

    $display("[TB] streaming port 0");
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(8); #1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(3);

    $display("[TB] back-to-back ports");
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(3);

    // Random traffic: a requester re-rolls only when idle or just granted.
    $display("[TB] random traffic");
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      g = {bus.gnt1, bus.gnt0};
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (((p == 0) ? !bus.req0 : !bus.req1) || g[p]) begin
          rnd = $urandom;
          ra  = (rnd[31:30] == 2'b00) ? rnd[15:0] : {12'h000, rnd[3:0]};
          rnd = $urandom;
          rd  = rnd[15:0];
          applyStimulus(p, rnd[17:16] != 2'b00, rnd[19:18] == 2'b00, ra, rd);
        end
      end
    end
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(4);
    @(negedge clk);
    checkEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
